// File: rtl/mux_pkg.sv
// Shared mode encodings and sequencer state type for the TDM multiplexer family.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    ST_MANUAL,
    ST_SCAN
  } state_t;

endpackage

// File: rtl/mux_n_comb.sv
// Pure combinational CHANNELS:1 WIDTH-bit selector; an out-of-range select yields zero.
module mux_n_comb #(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] a,
  output logic [WIDTH-1:0]          y_c
);

  always_comb begin
    y_c = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (sel == SEL_W'(k)) y_c = a[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/tdm_mux.sv
// N:1 registered multiplexer with a held manual select or a round-robin scan
// that dwells DWELL enabled cycles per channel.
module tdm_mux
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned DWELL    = 1,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      mode,
  input  logic                      load_sel,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [CHANNELS*WIDTH-1:0] a,
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          y_ch,
  output logic                      y_valid,
  output logic                      wrap,
  output logic                      sel_err
);

  localparam int unsigned     DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(CHANNELS - 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  sel, sel_nxt;
  logic [DW_W-1:0]   dwell_cnt, dwell_nxt;
  logic              wrap_pend, wrap_pend_nxt;
  logic [31:0]       sel_in_ext;
  logic              load_ok, load_bad;
  logic [WIDTH-1:0]  mux_y;

  mux_n_comb #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS)
  ) u_mux (
    .sel(sel),
    .a  (a),
    .y_c(mux_y)
  );

  // Classify the select strobe against the channel count.
  always_comb begin
    sel_in_ext = 32'(sel_in);
    load_ok    = load_sel && (sel_in_ext < CHANNELS);
    load_bad   = load_sel && !(sel_in_ext < CHANNELS);
  end

  // wrap_pend marks that sel has just stepped last -> 0, so the wrap pulse
  // lands with the first y sample taken from channel 0.
  always_comb begin
    state_nxt     = state;
    sel_nxt       = sel;
    dwell_nxt     = dwell_cnt;
    wrap_pend_nxt = wrap_pend;
    if (en) begin
      state_nxt     = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
      wrap_pend_nxt = 1'b0;
      if (load_ok) begin
        sel_nxt   = sel_in;
        dwell_nxt = '0;
      end else if (state_nxt != state) begin
        dwell_nxt = '0;
      end else if (state == ST_SCAN) begin
        if (dwell_cnt == DWELL_LAST) begin
          dwell_nxt     = '0;
          sel_nxt       = (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
          wrap_pend_nxt = (sel == SEL_LAST);
        end else begin
          dwell_nxt = dwell_cnt + DW_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_MANUAL;
      sel       <= '0;
      dwell_cnt <= '0;
      wrap_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      dwell_cnt <= dwell_nxt;
      wrap_pend <= wrap_pend_nxt;
    end
  end

  // Output registers: sample the current channel every enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
      wrap    <= 1'b0;
      sel_err <= 1'b0;
    end else if (en) begin
      y       <= mux_y;
      y_ch    <= sel;
      y_valid <= 1'b1;
      wrap    <= wrap_pend;
      sel_err <= load_bad;
    end else begin
      y_valid <= 1'b0;
      wrap    <= 1'b0;
      sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_mux.sv
// Bench for tdm_mux: three configurations share stimulus and are checked
// every cycle against a per-instance behavioural model, plus directed spot checks.
module tb_tdm_mux;

  localparam int NC [3] = '{4, 4, 3};
  localparam int ND [3] = '{1, 3, 2};

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic        load_sel;
  logic [1:0]  sel_in;
  logic [31:0] a_bus;

  logic [7:0]  y_o     [3];
  logic [1:0]  ch_o    [3];
  logic        v_o     [3];
  logic        wr_o    [3];
  logic        er_o    [3];

  int vectors;
  int miscompares;

  int m_sel [3];
  int m_dw  [3];
  int m_scn [3];
  int m_wp  [3];
  int e_y   [3];
  int e_ch  [3];
  int e_v   [3];
  int e_wr  [3];
  int e_er  [3];

  int seq_y  [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h11};
  int seq_wr [5] = '{0, 0, 0, 0, 1};

  tdm_mux #(.WIDTH(8), .CHANNELS(4), .DWELL(1)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load_sel(load_sel),
    .sel_in(sel_in), .a(a_bus), .y(y_o[0]), .y_ch(ch_o[0]), .y_valid(v_o[0]),
    .wrap(wr_o[0]), .sel_err(er_o[0]));

  tdm_mux #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load_sel(load_sel),
    .sel_in(sel_in), .a(a_bus), .y(y_o[1]), .y_ch(ch_o[1]), .y_valid(v_o[1]),
    .wrap(wr_o[1]), .sel_err(er_o[1]));

  tdm_mux #(.WIDTH(8), .CHANNELS(3), .DWELL(2)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load_sel(load_sel),
    .sel_in(sel_in), .a(a_bus[23:0]), .y(y_o[2]), .y_ch(ch_o[2]), .y_valid(v_o[2]),
    .wrap(wr_o[2]), .sel_err(er_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_sel[i] = 0; m_dw[i] = 0; m_scn[i] = 0; m_wp[i] = 0;
      e_y[i] = 0; e_ch[i] = 0; e_v[i] = 0; e_wr[i] = 0; e_er[i] = 0;
    end
  endtask

  // One clock edge of behaviour, from the stable inputs in front of it.
  task automatic model_edge();
    int req;
    int to_scan;
    req = int'(sel_in);
    to_scan = mode ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      if (en) begin
        e_y[i]  = int'((a_bus >> (8 * m_sel[i])) & 32'hff);
        e_ch[i] = m_sel[i];
        e_v[i]  = 1;
        e_wr[i] = m_wp[i];
        e_er[i] = (load_sel && req >= NC[i]) ? 1 : 0;
        m_wp[i] = 0;
        if (load_sel && req < NC[i]) begin
          m_sel[i] = req;
          m_dw[i]  = 0;
        end else if (to_scan != m_scn[i]) begin
          m_dw[i] = 0;
        end else if (m_scn[i] == 1) begin
          m_dw[i]++;
          if (m_dw[i] == ND[i]) begin
            m_dw[i]  = 0;
            m_wp[i]  = (m_sel[i] == NC[i] - 1) ? 1 : 0;
            m_sel[i] = (m_sel[i] + 1) % NC[i];
          end
        end
        m_scn[i] = to_scan;
      end else begin
        e_v[i] = 0; e_wr[i] = 0; e_er[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.y", i),       32'(y_o[i]),  e_y[i]);
      chk($sformatf("u%0d.y_ch", i),    32'(ch_o[i]), e_ch[i]);
      chk($sformatf("u%0d.y_valid", i), 32'(v_o[i]),  e_v[i]);
      chk($sformatf("u%0d.wrap", i),    32'(wr_o[i]), e_wr[i]);
      chk($sformatf("u%0d.sel_err", i), 32'(er_o[i]), e_er[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst.y0", 32'(y_o[0]), 0);
    chk("rst.valid0", 32'(v_o[0]), 0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; load_sel = 1'b0; sel_in = 2'd0;
    a_bus = 32'h44332211;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // Manual load of channel 2, held afterwards
    en = 1'b1; load_sel = 1'b1; sel_in = 2'd2;
    step();
    load_sel = 1'b0;
    step();
    chk("man.y", 32'(y_o[0]), 32'h33);
    chk("man.ch", 32'(ch_o[0]), 2);
    chk("man.valid", 32'(v_o[0]), 1);
    step();
    step();
    chk("man.hold", 32'(y_o[0]), 32'h33);

    async_reset();

    // Scan from channel 0, DWELL=1 sequence and wrap
    mode = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("scan.y[%0d]", k), 32'(y_o[0]), seq_y[k]);
      chk($sformatf("scan.wrap[%0d]", k), 32'(wr_o[0]), seq_wr[k]);
    end

    // Enable gap mid-dwell
    en = 1'b0;
    step();
    step();
    chk("gap.valid1", 32'(v_o[1]), 0);
    en = 1'b1;
    for (int k = 0; k < 4; k++) step();

    // Load override at sel=3 on terminal dwell
    n = 0;
    while (m_sel[0] != 3 && n < 8) begin
      step();
      n++;
    end
    chk("ovr.reach3", m_sel[0], 3);
    load_sel = 1'b1; sel_in = 2'd1;
    step();
    load_sel = 1'b0;
    chk("ovr.ch_before", 32'(ch_o[0]), 3);
    step();
    chk("ovr.ch", 32'(ch_o[0]), 1);
    chk("ovr.nowrap", 32'(wr_o[0]), 0);

    // Out-of-range select on the 3-channel instance
    load_sel = 1'b1; sel_in = 2'd3;
    step();
    load_sel = 1'b0;
    chk("oor.err2", 32'(er_o[2]), 1);
    chk("oor.err0", 32'(er_o[0]), 0);
    step();
    chk("oor.err2_clr", 32'(er_o[2]), 0);
    for (int k = 0; k < 8; k++) step();

    // Reset during scan at sel=2, then restart from channel 0
    n = 0;
    while (m_sel[2] != 2 && n < 12) begin
      step();
      n++;
    end
    chk("rscan.reach2", m_sel[2], 2);
    async_reset();
    chk("rscan.y2", 32'(y_o[2]), 0);
    chk("rscan.wrap2", 32'(wr_o[2]), 0);
    step();
    chk("rscan.ch2", 32'(ch_o[2]), 0);
    chk("rscan.y2_first", 32'(y_o[2]), 32'h11);

    // Randomised traffic
    for (int k = 0; k < 600; k++) begin
      en       = ($urandom % 8) != 0;
      if (($urandom % 16) == 0) mode = ~mode;
      load_sel = ($urandom % 6) == 0;
      sel_in   = 2'($urandom);
      a_bus    = $urandom;
      step();
      if (($urandom % 150) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
